// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback source names.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
  localparam int RF_DATA_W   = 64;
  localparam int RF_ZERO_REG = RF_NUM_REGS - 1;
  localparam int RF_NUM_SRC  = 4;

  // Writeback requester index assignment on the arbiter inputs
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_MUL  = 2'd2,
    SRC_LINK = 2'd3
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// Latency: grant is combinational; pointer advances on the granting edge.
// Backpressure: enable=0 suppresses all grants and freezes the pointer.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr;

  // Priority search starting at ptr and wrapping; first active request wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_vld && req[(int'(ptr) + k) % NUM_REQ]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port among writeback sources, one write per cycle.
// Latency: 1 cycle from grant to registered wr_en/wr_addr/wr_data/wr_valid.
// Backpressure: stall or reset blocks all req_ready; requesters hold until granted.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ     = RF_NUM_SRC,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int DATA_W      = RF_DATA_W,
  parameter bit ZERO_REG_EN = 1'b1,
  localparam int NUM_REGS   = 2 ** ADDR_W,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            stall,
  output logic [NUM_REGS-1:0]             wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            wr_valid
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NUM_REGS - 1);

  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_REGS-1:0] wr_en_nxt;

  // Reset is folded into the enable so no grant is visible while held in reset
  assign arb_en = ~stall & reset_n;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;

  // Select the winner's address/data and decode the one-hot enable
  always_comb begin
    sel_addr  = req_addr[grant_idx];
    sel_data  = req_data[grant_idx];
    wr_en_nxt = '0;
    if (grant_vld && !(ZERO_REG_EN && (sel_addr == ZERO_IDX))) begin
      wr_en_nxt[sel_addr] = 1'b1;
    end
  end

  // Output register; addr/data keep their last value when nothing is granted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en    <= wr_en_nxt;
      wr_valid <= grant_vld;
      if (grant_vld) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, hand-written corner cases,
// then randomized traffic against a request-queue reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle / 1 ns after the edge.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [3:0]            req_valid;
  logic [3:0][3:0]       req_addr;
  logic [3:0][63:0]      req_data;
  logic [3:0]            req_ready;
  logic                  stall;
  logic [15:0]           wr_en;
  logic [3:0]            wr_addr;
  logic [63:0]           wr_data;
  logic                  wr_valid;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arbiter #(
    .NUM_REQ     (4),
    .ADDR_W      (4),
    .DATA_W      (64),
    .ZERO_REG_EN (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   vld;
    logic [15:0]  addr;
    logic [255:0] data;
    logic         stl;
    logic [3:0]   e_rdy;
    logic [15:0]  e_en;
    logic         e_vld;
    logic [3:0]   e_addr;
    logic [63:0]  e_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called 1 ns after a rising edge with inputs already applied: checks the
  // combinational grant mid-cycle, then the registered write after the next edge.
  task automatic check_cycle(input string tag, input logic [3:0] er, input logic [15:0] een,
                             input logic ev, input logic [3:0] ea, input logic [63:0] ed);
    #4;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    chk({tag, ".wr_en"},    64'(wr_en),    64'(een));
    chk({tag, ".wr_valid"}, 64'(wr_valid), 64'(ev));
    chk({tag, ".wr_addr"},  64'(wr_addr),  64'(ea));
    chk({tag, ".wr_data"},  wr_data,       ed);
    chk({tag, ".onehot"},   64'($countones(wr_en) <= 1), 64'd1);
  endtask

  // Reference: requesters examined in rotating order from ptr; first pending one wins
  function automatic int pick(input logic [3:0] v, input int p);
    int order[$];
    for (int k = 0; k < 4; k++) order.push_back((p + k) % 4);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [15:0] dec(input logic [3:0] a);
    logic [15:0] one;
    one = 16'h1;
    return (a == 4'(RF_ZERO_REG)) ? 16'h0 : (one << a);
  endfunction

  initial begin
    // ---------- directed vectors, starting from ptr=1 after the reset sequence ----------
    tbl[0] = '{vld:4'b0000, addr:16'h0, data:256'h0, stl:1'b0,
               e_rdy:4'b0000, e_en:16'h0000, e_vld:1'b0, e_addr:4'h3, e_data:64'h11};
    tbl[1] = '{vld:4'b0010, addr:16'h0050, data:{128'h0, 64'hA5, 64'h0}, stl:1'b0,
               e_rdy:4'b0010, e_en:16'h0020, e_vld:1'b1, e_addr:4'h5, e_data:64'hA5};
    tbl[2] = '{vld:4'b0000, addr:16'h0, data:256'h0, stl:1'b0,
               e_rdy:4'b0000, e_en:16'h0000, e_vld:1'b0, e_addr:4'h5, e_data:64'hA5};
    tbl[3] = '{vld:4'b1000, addr:16'h9000, data:{64'h33, 192'h0}, stl:1'b0,
               e_rdy:4'b1000, e_en:16'h0200, e_vld:1'b1, e_addr:4'h9, e_data:64'h33};
    tbl[4] = '{vld:4'b1111, addr:16'h4321, data:{64'hD3, 64'hD2, 64'hD1, 64'hD0}, stl:1'b0,
               e_rdy:4'b0001, e_en:16'h0002, e_vld:1'b1, e_addr:4'h1, e_data:64'hD0};
    tbl[5] = '{vld:4'b1111, addr:16'h4321, data:{64'hD3, 64'hD2, 64'hD1, 64'hD0}, stl:1'b0,
               e_rdy:4'b0010, e_en:16'h0004, e_vld:1'b1, e_addr:4'h2, e_data:64'hD1};
    tbl[6] = '{vld:4'b1111, addr:16'h4321, data:{64'hD3, 64'hD2, 64'hD1, 64'hD0}, stl:1'b0,
               e_rdy:4'b0100, e_en:16'h0008, e_vld:1'b1, e_addr:4'h3, e_data:64'hD2};
    tbl[7] = '{vld:4'b1111, addr:16'h4321, data:{64'hD3, 64'hD2, 64'hD1, 64'hD0}, stl:1'b0,
               e_rdy:4'b1000, e_en:16'h0010, e_vld:1'b1, e_addr:4'h4, e_data:64'hD3};
    tbl[8] = '{vld:4'b1111, addr:16'h4321, data:{64'hD3, 64'hD2, 64'hD1, 64'hD0}, stl:1'b0,
               e_rdy:4'b0001, e_en:16'h0002, e_vld:1'b1, e_addr:4'h1, e_data:64'hD0};
    tbl[9] = '{vld:4'b0001, addr:16'h000F, data:{192'h0, 64'hFF}, stl:1'b0,
               e_rdy:4'b0001, e_en:16'h0000, e_vld:1'b1, e_addr:4'hF, e_data:64'hFF};

    // ---------- reset with all requesters asserted ----------
    reset_n   = 1'b0;
    stall     = 1'b0;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_data  = '0;
    req_addr[SRC_ALU] = 4'd3;
    req_data[SRC_ALU] = 64'h11;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'h0);
    chk("rst.wr_en",     64'(wr_en),     64'h0);
    chk("rst.wr_valid",  64'(wr_valid),  64'h0);
    chk("rst.wr_addr",   64'(wr_addr),   64'h0);
    chk("rst.wr_data",   wr_data,        64'h0);
    reset_n = 1'b1;
    check_cycle("rst_release", 4'b0001, 16'h0008, 1'b1, 4'h3, 64'h11);

    // ---------- table ----------
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].vld;
      req_addr  = tbl[i].addr;
      req_data  = tbl[i].data;
      stall     = tbl[i].stl;
      check_cycle($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_en, tbl[i].e_vld,
                  tbl[i].e_addr, tbl[i].e_data);
    end

    // ---------- stall with ptr=2, reqs 0 and 2 pending ----------
    req_valid = 4'b0010; req_addr = '0; req_data = '0;
    req_addr[1] = 4'd6; req_data[1] = 64'h66;
    check_cycle("stall_pre", 4'b0010, 16'h0040, 1'b1, 4'h6, 64'h66);
    req_valid = 4'b0101;
    req_addr[0] = 4'd8;  req_data[0] = 64'h80;
    req_addr[2] = 4'd10; req_data[2] = 64'hA0;
    stall = 1'b1;
    for (int c = 0; c < 3; c++)
      check_cycle($sformatf("stall%0d", c), 4'b0000, 16'h0000, 1'b0, 4'h6, 64'h66);
    stall = 1'b0;
    check_cycle("stall_rel0", 4'b0100, 16'h0400, 1'b1, 4'hA, 64'hA0);
    req_valid = 4'b0001;
    check_cycle("stall_rel1", 4'b0001, 16'h0100, 1'b1, 4'h8, 64'h80);

    // ---------- same-address conflict with ptr=3, then async reset ----------
    req_valid = 4'b0100; req_addr[2] = 4'd2; req_data[2] = 64'h22;
    check_cycle("conf_pre", 4'b0100, 16'h0004, 1'b1, 4'h2, 64'h22);
    req_valid = 4'b1001;
    req_addr[0] = 4'd7; req_data[0] = 64'h70;
    req_addr[3] = 4'd7; req_data[3] = 64'h73;
    check_cycle("conf0", 4'b1000, 16'h0080, 1'b1, 4'h7, 64'h73);
    req_valid = 4'b0001;
    check_cycle("conf1", 4'b0001, 16'h0080, 1'b1, 4'h7, 64'h70);
    reset_n = 1'b0;
    #1;
    chk("arst.wr_en",     64'(wr_en),     64'h0);
    chk("arst.wr_valid",  64'(wr_valid),  64'h0);
    chk("arst.wr_addr",   64'(wr_addr),   64'h0);
    chk("arst.wr_data",   wr_data,        64'h0);
    chk("arst.req_ready", 64'(req_ready), 64'h0);
    req_valid = 4'b1111;
    req_addr[0] = 4'd4; req_data[0] = 64'h44;
    reset_n = 1'b1;
    check_cycle("arst_ptr0", 4'b0001, 16'h0010, 1'b1, 4'h4, 64'h44);

    // ---------- randomized traffic against the reference model ----------
    begin
      logic [3:0]        pend;
      logic [3:0][3:0]   ra;
      logic [3:0][63:0]  rd;
      int                m_ptr;
      logic [15:0]       m_en;
      logic              m_vld;
      logic [3:0]        m_addr;
      logic [63:0]       m_data;
      logic [3:0]        e_rdy;
      int                g;
      logic              st;

      req_valid = '0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pend = '0; ra = '0; rd = '0;
      m_ptr = 0; m_en = '0; m_vld = 1'b0; m_addr = '0; m_data = '0;

      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
            pend[i] = 1'b1;
            ra[i] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rd[i] = {$urandom, $urandom};
          end
        end
        st = ($urandom_range(0, 3) == 0);
        req_valid = pend; req_addr = ra; req_data = rd; stall = st;

        g = st ? -1 : pick(pend, m_ptr);
        e_rdy = '0;
        if (g >= 0) begin
          e_rdy[g] = 1'b1;
          m_vld  = 1'b1;
          m_addr = ra[g];
          m_data = rd[g];
          m_en   = dec(ra[g]);
          m_ptr  = (g + 1) % 4;
          pend[g] = 1'b0;
        end else begin
          m_vld = 1'b0;
          m_en  = '0;
        end
        check_cycle($sformatf("rnd%0d", cyc), e_rdy, m_en, m_vld, m_addr, m_data);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port among NUM_REQ writeback sources (ALU, load unit, multiplier, branch-link). Uses round-robin arbitration to grant at most one request per cycle. The winning address is decoded to a one-hot per-register write enable and registered, together with the data, for the register file. It sits between the writeback stage and the register file and replaces the ad-hoc enable decode.

Parameters:
NUM_REQ, 4, number of writeback requesters (>=2)
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
DATA_W, 64, write data width
ZERO_REG_EN, 1, when 1, register NUM_REGS-1 is hardwired zero; writes to it are accepted but discarded

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ x ADDR_W  per-requester destination register
req_data  input  NUM_REQ x DATA_W  per-requester write data
req_ready  output  NUM_REQ  grant; one-hot or zero, combinational in same cycle
stall  input  1  register file busy; no grants while high
wr_en  output  NUM_REGS  registered one-hot write enable to register file
wr_addr  output  ADDR_W  registered granted address (debug/bypass)
wr_data  output  DATA_W  registered granted data
wr_valid  output  1  registered: a write is being presented this cycle (includes discarded zero-reg writes)

Behaviour:
- Handshake: a transfer occurs on requester i when req_valid[i] && req_ready[i] at a rising edge. Requesters hold valid/addr/data stable until granted.
- req_ready is combinational from req_valid, stall and the RR pointer. It never depends on req_addr or req_data.
- Arbitration: a priority search starting at pointer ptr (0..NUM_REQ-1), wrapping. The first valid index wins. At most one req_ready bit is high.
- stall=1: req_ready all zero, ptr unchanged.
- Pointer: after a grant to index g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Latency: 1 cycle. Outputs at edge k+1 reflect the grant at edge k:
  - wr_valid=1, wr_addr=addr_g, wr_data=data_g.
  - wr_en = 1<<addr_g, except all zero when ZERO_REG_EN && addr_g==NUM_REGS-1.
- No grant in a cycle: next cycle wr_valid=0 and wr_en=0. wr_addr and wr_data hold their previous values.
- wr_en is always one-hot or zero; never multiple bits.
- Same address requested by two sources in one cycle: only the RR winner is written that cycle. The loser is written in a later cycle (last writer in grant order wins). No merging.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles of stall-free operation.
- Reset (asynchronous assert, synchronous deassert expected externally):
  - ptr=0, wr_en=0, wr_valid=0, wr_addr=0, wr_data=0.
  - req_ready=0 while reset_n=0.
  - Reset mid-transfer drops the registered write. Requesters must re-present.
- The first rising edge after reset deassertion arbitrates normally.

Decomposition:
- Shared package regfile_pkg: ADDR_W, NUM_REGS, DATA_W defaults, ZERO_REG index constant, and an enum wb_src_e naming requester indices (SRC_ALU=0, SRC_LOAD=1, SRC_MUL=2, SRC_LINK=3).
- One sub-module: rr_arbiter (NUM_REQ parameter). It takes req, enable (= !stall) and owns the ptr register. It outputs a one-hot grant and a grant index.
- The address mux, one-hot decode and output register live in the top block.

Test Plan:
- Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0000, wr_en=0, wr_valid=0. Release -> the first grant goes to req 0.
- Single source: req 1 valid, addr=5, data=0xA5 -> req_ready=0010 the same cycle. Next cycle wr_en=0x0020, wr_addr=5, wr_data=0xA5, wr_valid=1. The cycle after, wr_en=0.
- Round robin: all 4 valid continuously, addrs 1,2,3,4 -> grant order 0,1,2,3,0; wr_en sequence 0x0002, 0x0004, 0x0008, 0x0010, 0x0002.
- Stall: ptr=2 with reqs 0 and 2 valid; stall=1 for 3 cycles -> no ready, wr_valid=0. Stall drops -> req 2 granted first, then req 0.
- Zero register: ZERO_REG_EN=1, req 0 addr=15, data=0xFF -> req_ready[0]=1. Next cycle wr_valid=1, wr_en=0x0000.
- Same-address conflict and async reset: reqs 0 and 3 both addr=7, ptr=3 -> req 3 written first, then req 0. Assert reset_n=0 mid-cycle after the req 0 grant -> wr_en goes 0 immediately (asynchronously) and ptr returns to 0.
